// File: rtl/copy_fifo_arbiter_if.sv
// Handshake bundle between copy_fifo_arbiter, its token FIFOs and the copy engine.
// The arbiter takes the master modport; the FIFO/copy-engine side takes the slave modport.
interface copy_fifo_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 33,
  parameter int SRC_W   = 2
);
  logic [NUM_REQ-1:0]       fifo_empty;
  logic [NUM_REQ*WIDTH-1:0] fifo_dout;
  logic [NUM_REQ-1:0]       fifo_rd_en;
  logic                     tok_valid;
  logic [WIDTH-1:0]         tok_data;
  logic [SRC_W-1:0]         tok_src;
  logic                     tok_ready;

  modport master (
    input  fifo_empty, fifo_dout, tok_ready,
    output fifo_rd_en, tok_valid, tok_data, tok_src
  );

  modport slave (
    output fifo_empty, fifo_dout, tok_ready,
    input  fifo_rd_en, tok_valid, tok_data, tok_src
  );
endinterface

// File: rtl/copy_fifo_arbiter.sv
// Round-robin scheduler feeding one copy engine from NUM_REQ registered-output token FIFOs.
// Optional burst locking (no interleave within a copy burst) is enabled by COPY_ARB_BURST_LOCK_EN.
module copy_fifo_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 33,
  parameter int SRC_W   = 2
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 arb_en,
  output logic                 busy,
  copy_fifo_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  occ_t             r_occ;
  logic [WIDTH-1:0] r_head_data;
  logic [WIDTH-1:0] r_skid_data;
  logic [SRC_W-1:0] r_head_src;
  logic [SRC_W-1:0] r_skid_src;
  logic             r_inflight;
  logic [SRC_W-1:0] r_inflight_src;
  logic [SRC_W-1:0] r_rr_ptr;

  logic               w_accept;
  logic               w_credit;
  logic               w_grant;
  logic [SRC_W-1:0]   w_grant_idx;
  logic [SRC_W-1:0]   w_next_ptr;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_rd_en;
  logic [NUM_REQ-1:0] w_lock_mask;
  logic [WIDTH-1:0]   w_cap_data;

  assign bus.tok_valid  = (r_occ != OCC_EMPTY);
  assign bus.tok_data   = r_head_data;
  assign bus.tok_src    = r_head_src;
  assign bus.fifo_rd_en = w_rd_en;
  assign busy           = (r_occ != OCC_EMPTY) || r_inflight;

  assign w_accept = bus.tok_valid && bus.tok_ready;
  // occ + inflight - accept < 2, rearranged to stay unsigned
  assign w_credit = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_accept});

  always_comb begin
    w_cap_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_inflight_src == SRC_W'(i)) begin
        w_cap_data = bus.fifo_dout[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef COPY_ARB_BURST_LOCK_EN
  logic             r_lock;
  logic [SRC_W-1:0] r_lock_src;
  logic             w_lock_hold;

  // Lock is taken speculatively at grant; the in-flight token is visible on
  // fifo_dout the following cycle, so a last-of-burst flag releases it without a bubble.
  assign w_lock_hold = r_lock &&
                       !(r_inflight && (r_inflight_src == r_lock_src) && w_cap_data[WIDTH-1]);

  always_comb begin
    w_lock_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_lock_mask[i] = !w_lock_hold || (r_lock_src == SRC_W'(i));
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_lock     <= 1'b0;
      r_lock_src <= '0;
    end else if (w_grant) begin
      r_lock     <= 1'b1;
      r_lock_src <= w_grant_idx;
    end else if (!w_lock_hold) begin
      r_lock     <= 1'b0;
    end
  end
`else
  assign w_lock_mask = '1;
`endif

  assign w_elig = ~bus.fifo_empty & w_lock_mask & {NUM_REQ{arb_en && w_credit && !srst}};

  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = '0;
    w_next_ptr  = r_rr_ptr;
    w_rd_en     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!w_grant && w_elig[i] && (((32'(r_rr_ptr) + k) % NUM_REQ) == i)) begin
          w_grant     = 1'b1;
          w_grant_idx = SRC_W'(i);
          w_next_ptr  = (i == NUM_REQ - 1) ? '0 : SRC_W'(i + 1);
          w_rd_en[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_occ          <= OCC_EMPTY;
      r_head_data    <= '0;
      r_skid_data    <= '0;
      r_head_src     <= '0;
      r_skid_src     <= '0;
      r_inflight     <= 1'b0;
      r_inflight_src <= '0;
      r_rr_ptr       <= '0;
    end else begin
      r_inflight <= w_grant;
      if (w_grant) begin
        r_inflight_src <= w_grant_idx;
        r_rr_ptr       <= w_next_ptr;
      end
      case (r_occ)
        OCC_EMPTY: begin
          if (r_inflight) begin
            r_head_data <= w_cap_data;
            r_head_src  <= r_inflight_src;
            r_occ       <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (r_inflight) begin
            if (w_accept) begin
              r_head_data <= w_cap_data;
              r_head_src  <= r_inflight_src;
            end else begin
              r_skid_data <= w_cap_data;
              r_skid_src  <= r_inflight_src;
              r_occ       <= OCC_TWO;
            end
          end else if (w_accept) begin
            r_occ <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (w_accept) begin
            r_head_data <= r_skid_data;
            r_head_src  <= r_skid_src;
            if (r_inflight) begin
              r_skid_data <= w_cap_data;
              r_skid_src  <= r_inflight_src;
            end else begin
              r_occ <= OCC_ONE;
            end
          end
        end
        default: r_occ <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: doc/copy_fifo_arbiter.md
Name: copy_fifo_arbiter

Overview:
- Round-robin scheduler that shares a single downstream copy engine among NUM_REQ parser-to-copy token FIFOs in the snappy decompressor.
- Issues rd_en to at most one FIFO per cycle and absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer.
- Presents tokens to the copy engine over a valid/ready handshake, tagged with the source index.
- Never reads an empty FIFO and never drops a token under backpressure.

Parameters:
- NUM_REQ, 4, number of requesting FIFOs (2..8).
- WIDTH, 33, token width; bit WIDTH-1 is the last-of-burst flag.
- SRC_W, 2, width of source index; must satisfy 2**SRC_W >= NUM_REQ.

Ports:
- clk  input  1  clock; all logic on rising edge.
- srst  input  1  asynchronous active-high reset.
- arb_en  input  1  when 0, no new FIFO reads start; buffered and in-flight tokens still drain.
- fifo_empty  input  NUM_REQ  empty flag of each FIFO; bit i belongs to requester i.
- fifo_dout  input  NUM_REQ*WIDTH  FIFO outputs; slice i is [i*WIDTH +: WIDTH].
- fifo_rd_en  output  NUM_REQ  read strobe per FIFO; one-hot or zero.
- tok_valid  output  1  token available to the copy engine.
- tok_data  output  WIDTH  token payload.
- tok_src  output  SRC_W  index of the FIFO the token came from.
- tok_ready  input  1  copy engine accepts the token when tok_valid and tok_ready are both 1.
- busy  output  1  high while the buffer is non-empty or a read is in flight.

Behaviour:
- Reset:
  - srst=1 asynchronously clears buffer, inflight flag and rr_ptr.
  - Outputs during reset: fifo_rd_en=0, tok_valid=0, tok_data=0, tok_src=0, busy=0.
  - An in-flight read at reset assertion is discarded.
- FIFO read timing:
  - FIFO dout is registered; data is valid in the cycle after rd_en.
  - The arbiter keeps a registered inflight flag and an inflight_src index.
  - Read captured data from the fifo_dout slice inflight_src at the next edge.
- Buffer:
  - 2 entries (head, skid), FIFO order, each entry holds {data, src}.
  - occ ranges 0..2.
  - Credit rule: a new read may issue only if occ + inflight - (tok_valid & tok_ready) < 2, so a captured token always has a free slot.
- Grant, combinational each cycle:
  - Eligible(i) = !fifo_empty[i] & arb_en & credit.
  - Search starts at rr_ptr, then rr_ptr+1, ... modulo NUM_REQ; the first eligible index g gets fifo_rd_en[g]=1.
  - On grant, rr_ptr <= (g+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
  - No eligible index: rd_en stays zero and rr_ptr holds.
- Back-to-back reads:
  - The same FIFO may be read on consecutive cycles.
  - fifo_empty is already updated one cycle after rd_en, so no extra guard is needed.
- Latency and throughput:
  - rd_en in cycle t gives tok_valid=1 in cycle t+2 (capture at end of t+1).
  - Sustained throughput is 1 token/cycle with tok_ready held high.
- Output:
  - tok_data and tok_src come from the head entry; tok_valid = (occ != 0).
  - On accept, skid moves to head.
  - Capture and accept may happen in the same cycle: occ stays the same and order is preserved.
- Backpressure:
  - With tok_ready=0, at most 2 tokens are buffered and reads then stop.
  - tok_data and tok_src stay stable while tok_valid=1 and tok_ready=0.
- arb_en dropped mid-stream: an in-flight read still completes and its token is delivered.
- Illegal case: fifo_empty dropping for a FIFO mid-cycle has no effect on the current grant; grant depends only on sampled values.

Optional Feature:
- Macro: COPY_ARB_BURST_LOCK_EN.
- Defined:
  - After a grant to requester g whose token has bit WIDTH-1 = 0, the arbiter locks onto g.
  - While locked, only g is eligible.
  - Lock releases when a token from g with bit WIDTH-1 = 1 is captured.
  - Lock state is cleared by srst.
  - While g is empty and locked, no reads are issued, so a copy burst is never interleaved with another source.
- Undefined: pure round-robin per token; bit WIDTH-1 is ignored by the arbiter.

Test Plan:
- Single source: NUM_REQ=4, only FIFO 2 holds tokens 0x0A, 0x0B, tok_ready=1 -> rd_en=4'b0100 in cycles t and t+1; tok_valid in t+2 and t+3; data 0x0A then 0x0B; tok_src=2.
- Round-robin fairness: all 4 FIFOs non-empty with 3 tokens each, tok_ready=1 -> grant order 0,1,2,3,0,1,2,3,...; 12 tokens output with no gaps after the initial 2-cycle latency.
- Backpressure: FIFO 0 holds 5 tokens, tok_ready=0 for 10 cycles -> exactly 2 rd_en pulses, then rd_en=0. Raising tok_ready gives all 5 tokens in order, none lost or duplicated.
- Empty safety: FIFO 1 holds 1 token -> exactly one rd_en[1] pulse; fifo_rd_en[i]=1 never occurs while fifo_empty[i]=1 (assertion).
- Reset mid-operation: srst pulsed while occ=2 and a read is in flight -> tok_valid=0 and busy=0 immediately. After release, the arbiter resumes at rr_ptr=0.
- Burst lock (macro defined): FIFO 0 holds tokens with MSB 0,0,1 and FIFO 1 holds tokens with MSB 1 -> output sources are 0,0,0,1. With the macro undefined -> sources are 0,1,0,0.
